layer_controller: RTL and testbench

//  Sequences one fully-connected layer of neuron instances.
//  - Accepts an input vector as a valid/ready stream and broadcasts each word to every

---
 rtl/layer_controller_pkg.sv | 27 ++
 rtl/layer_controller_result_bank.sv | 46 ++++
 rtl/layer_controller.sv | 167 ++++++++++++++++
 tb/tb_layer_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_controller_pkg.sv
// Shared definitions for the layer controller: FSM state encoding and
// width helpers used to size counters and index buses.
package layer_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits for a single entry.
    function automatic int idx_width(input int entries);
        return (clog2(entries) < 1) ? 1 : clog2(entries);
    endfunction

endpackage

// File: rtl/layer_controller_result_bank.sv
// Per-neuron result capture: one register and one "got" flag per neuron,
// first capture wins, and a read mux selecting the result being drained.
module layer_controller_result_bank
    import layer_controller_pkg::*;
#(
    parameter int numNeuron = 30,
    parameter int dataWidth = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear_i,
    input  logic                           capture_en_i,
    input  logic [numNeuron-1:0]           valid_i,
    input  logic [numNeuron*dataWidth-1:0] data_i,
    input  logic [idx_width(numNeuron)-1:0] rd_idx_i,
    output logic [dataWidth-1:0]           rd_data_o,
    output logic [numNeuron-1:0]           got_o,
    output logic [numNeuron-1:0]           dup_o
);

    logic [dataWidth-1:0] res_q [numNeuron];
    logic [numNeuron-1:0] got_q;

    // Capture each neuron's first result while capturing is enabled; later
    // pulses on the same neuron leave the stored value untouched.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            got_q <= '0;
            for (int i = 0; i < numNeuron; i++) begin
                res_q[i] <= '0;
            end
        end else if (capture_en_i) begin
            for (int i = 0; i < numNeuron; i++) begin
                if (valid_i[i] && !got_q[i]) begin
                    res_q[i] <= data_i[i*dataWidth +: dataWidth];
                    got_q[i] <= 1'b1;
                end
            end
        end
    end

    assign got_o     = got_q;
    assign dup_o     = {numNeuron{capture_en_i}} & valid_i & got_q;
    assign rd_data_o = res_q[rd_idx_i];

endmodule

// File: rtl/layer_controller.sv
// Sequences one fully-connected layer: broadcasts the input vector to all
// neurons, gathers their results (with a timeout), then streams the results
// out in neuron index order.
module layer_controller
    import layer_controller_pkg::*;
#(
    parameter int numNeuron  = 30,
    parameter int numWeight  = 784,
    parameter int dataWidth  = 16,
    parameter int timeoutCyc = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [dataWidth-1:0]           s_data,
    input  logic                           s_valid,
    output logic                           s_ready,
    output logic [dataWidth-1:0]           n_input,
    output logic                           n_inputValid,
    input  logic [numNeuron-1:0]           n_outValid,
    input  logic [numNeuron*dataWidth-1:0] n_out,
    output logic [dataWidth-1:0]           m_data,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic                           busy,
    output logic                           layer_done,
    output logic                           err
);

    localparam int IN_W  = clog2(numWeight + 1);
    localparam int IDX_W = idx_width(numNeuron);
    localparam int WT_W  = idx_width(timeoutCyc + 1);

    state_t               state_q;
    logic [IN_W-1:0]      in_cnt_q;
    logic [IDX_W-1:0]     out_idx_q;
    logic [WT_W-1:0]      wait_cnt_q;
    logic                 s_ready_q;
    logic [dataWidth-1:0] n_input_q;
    logic                 n_input_valid_q;
    logic                 layer_done_q;
    logic                 err_q;

    logic                 accept;
    logic                 capture_en;
    logic                 last_out;
    logic                 bank_clear;
    logic [numNeuron-1:0] got;
    logic [numNeuron-1:0] dup;
    logic [numNeuron-1:0] got_after;
    logic [dataWidth-1:0] bank_data;

    assign accept     = s_valid && s_ready_q;
    assign capture_en = (state_q == ST_WAIT);
    assign last_out   = (out_idx_q == IDX_W'(numNeuron - 1));
    assign bank_clear = (state_q == ST_DRAIN) && m_ready && last_out;
    // Mask as it will stand after this cycle's captures.
    assign got_after  = got | n_outValid;

    layer_controller_result_bank #(
        .numNeuron (numNeuron),
        .dataWidth (dataWidth)
    ) u_bank (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (bank_clear),
        .capture_en_i (capture_en),
        .valid_i      (n_outValid),
        .data_i       (n_out),
        .rd_idx_i     (out_idx_q),
        .rd_data_o    (bank_data),
        .got_o        (got),
        .dup_o        (dup)
    );

    // Main sequencer: state, counters, broadcast register and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            in_cnt_q        <= '0;
            out_idx_q       <= '0;
            wait_cnt_q      <= '0;
            s_ready_q       <= 1'b0;
            n_input_q       <= '0;
            n_input_valid_q <= 1'b0;
            layer_done_q    <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            n_input_valid_q <= accept;
            if (accept) begin
                n_input_q <= s_data;
            end
            layer_done_q <= 1'b0;

            // Results arriving when nobody is waiting, or twice, are errors.
            if ((state_q != ST_WAIT) && (|n_outValid)) begin
                err_q <= 1'b1;
            end
            if (|dup) begin
                err_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        in_cnt_q <= IN_W'(1);
                        if (numWeight == 1) begin
                            state_q    <= ST_WAIT;
                            s_ready_q  <= 1'b0;
                            wait_cnt_q <= '0;
                        end else begin
                            state_q <= ST_FEED;
                        end
                    end
                end
                ST_FEED: begin
                    if (accept) begin
                        in_cnt_q <= in_cnt_q + 1'b1;
                        if (in_cnt_q == IN_W'(numWeight - 1)) begin
                            state_q    <= ST_WAIT;
                            s_ready_q  <= 1'b0;
                            wait_cnt_q <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // A capture completing the mask beats a timeout in the same cycle.
                    if (&got_after) begin
                        state_q <= ST_DRAIN;
                    end else if (wait_cnt_q == WT_W'(timeoutCyc - 1)) begin
                        err_q   <= 1'b1;
                        state_q <= ST_DRAIN;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (m_ready) begin
                        if (last_out) begin
                            state_q      <= ST_IDLE;
                            s_ready_q    <= 1'b1;
                            out_idx_q    <= '0;
                            in_cnt_q     <= '0;
                            wait_cnt_q   <= '0;
                            layer_done_q <= 1'b1;
                        end else begin
                            out_idx_q <= out_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign n_input      = n_input_q;
    assign n_inputValid = n_input_valid_q;
    assign m_valid      = (state_q == ST_DRAIN);
    assign m_data       = m_valid ? bank_data : '0;
    assign busy         = (state_q != ST_IDLE);
    assign layer_done   = layer_done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_layer_controller.sv
// Bench for layer_controller: directed scenarios plus randomized vectors,
// each checked against a layer-level model of broadcast, capture and drain.
module tb_layer_controller;

    localparam int NN = 3;
    localparam int NW = 4;
    localparam int DW = 16;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic [DW-1:0]    s_data;
    logic             s_valid;
    logic             s_ready;
    logic [DW-1:0]    n_input;
    logic             n_inputValid;
    logic [NN-1:0]    n_outValid;
    logic [NN*DW-1:0] n_out;
    logic [DW-1:0]    m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             layer_done;
    logic             err;

    always #5 clk = ~clk;

    layer_controller #(
        .numNeuron (NN),
        .numWeight (NW),
        .dataWidth (DW),
        .timeoutCyc(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .n_input     (n_input),
        .n_inputValid(n_inputValid),
        .n_outValid  (n_outValid),
        .n_out       (n_out),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .busy        (busy),
        .layer_done  (layer_done),
        .err         (err)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Scenario description consumed by run_layer.
    logic [DW-1:0] words [NW];
    int            sched [NN];   // WAIT cycle at which neuron i pulses, -1 = never
    logic [DW-1:0] vals  [NN];
    int            gap_pct;
    int            ready_mode;   // 0 always ready, 1 pattern 1,0,0,1, 2 random
    int            dup_req;      // neuron to pulse a second time, -1 = none
    logic          err_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        s_valid    = 1'b0;
        s_data     = '0;
        n_outValid = '0;
        m_ready    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_n_inputValid", n_inputValid, 0);
        chk("rst_n_input", n_input, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_layer_done", layer_done, 0);
        chk("rst_err", err, 0);
        reset   = 1'b0;
        err_exp = 1'b0;
        @(negedge clk);
    endtask

    // One whole vector: feed, wait for results, drain, with the expected
    // outcome computed up front from the pulse schedule.
    task automatic run_layer(input string name);
        logic [DW-1:0] exp_res [NN];
        logic          all_got;
        int            last_w, end_w, dup_w, idx, cyc, hs;
        logic          acc, prev_acc, rdy;
        logic [DW-1:0] prev_word;
        logic [NN-1:0] nov;

        // Reference: a neuron counts if it pulses before the layer stops waiting.
        all_got = 1'b1;
        last_w  = 0;
        for (int i = 0; i < NN; i++) begin
            if (sched[i] < 0 || sched[i] >= TO) all_got = 1'b0;
            else if (sched[i] > last_w) last_w = sched[i];
        end
        end_w = all_got ? last_w : TO - 1;
        for (int i = 0; i < NN; i++) begin
            exp_res[i] = (sched[i] >= 0 && sched[i] <= end_w) ? vals[i] : '0;
        end
        if (!all_got) err_exp = 1'b1;
        dup_w = -1;
        if (dup_req >= 0 && sched[dup_req] >= 0 && sched[dup_req] < end_w) begin
            dup_w   = sched[dup_req] + 1 + $urandom_range(end_w - sched[dup_req] - 1);
            err_exp = 1'b1;
        end

        // Feed phase.
        idx = 0; cyc = 0; prev_acc = 1'b0; prev_word = '0;
        while (idx < NW && cyc < 200) begin
            chk({name, ":feed_in_valid"}, n_inputValid, prev_acc);
            if (prev_acc) chk({name, ":feed_in_data"}, n_input, prev_word);
            s_valid = ($urandom_range(99) >= gap_pct);
            s_data  = s_valid ? words[idx] : DW'($urandom);
            acc     = s_valid && s_ready;
            if (acc) begin
                prev_word = words[idx];
                idx++;
            end
            prev_acc = acc;
            @(negedge clk);
            cyc++;
        end
        if (idx < NW) chk({name, ":feed_timeout"}, idx, NW);
        chk({name, ":last_in_valid"}, n_inputValid, 1);
        chk({name, ":last_in_data"}, n_input, words[NW-1]);
        chk({name, ":s_ready_drop"}, s_ready, 0);
        chk({name, ":busy_wait"}, busy, 1);

        // Wait phase: neurons pulse per schedule, input stream stays blocked.
        for (int w = 0; w <= end_w; w++) begin
            if (w > 0) chk({name, ":wait_in_valid"}, n_inputValid, 0);
            chk({name, ":wait_m_valid"}, m_valid, 0);
            chk({name, ":wait_s_ready"}, s_ready, 0);
            nov = '0;
            for (int i = 0; i < NN; i++) begin
                if (sched[i] == w) begin
                    nov[i] = 1'b1;
                    n_out[i*DW +: DW] = vals[i];
                end
            end
            if (w == dup_w) begin
                nov[dup_req] = 1'b1;
                n_out[dup_req*DW +: DW] = ~vals[dup_req];
            end
            n_outValid = nov;
            s_valid    = 1'($urandom_range(1));
            s_data     = DW'($urandom);
            @(negedge clk);
        end
        n_outValid = '0;
        chk({name, ":drain_in_valid"}, n_inputValid, 0);
        chk({name, ":err_at_drain"}, err, err_exp);

        // Drain phase.
        hs = 0; cyc = 0;
        while (hs < NN && cyc < 100) begin
            chk({name, ":drain_m_valid"}, m_valid, 1);
            chk({name, ":drain_m_data"}, m_data, exp_res[hs]);
            chk({name, ":drain_s_ready"}, s_ready, 0);
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(1));
            endcase
            m_ready = rdy;
            if (rdy) hs++;
            @(negedge clk);
            cyc++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        chk({name, ":handshakes"}, hs, NN);
        chk({name, ":done_m_valid"}, m_valid, 0);
        chk({name, ":layer_done"}, layer_done, 1);
        chk({name, ":done_busy"}, busy, 0);
        chk({name, ":done_err"}, err, err_exp);
        @(negedge clk);
        chk({name, ":layer_done_pulse"}, layer_done, 0);
        $display("vector %s done: handshakes=%0d err=%0b", name, hs, err);
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_data = '0;
        n_outValid = '0; n_out = '0; m_ready = 1'b0;
        err_exp = 1'b0; dup_req = -1; gap_pct = 0; ready_mode = 0;

        // Words 1..4 back-to-back, results arriving from neurons 2,0,1.
        do_reset();
        words = '{16'd1, 16'd2, 16'd3, 16'd4};
        sched = '{1, 2, 0};
        vals  = '{16'h0022, 16'h0033, 16'h0011};
        run_layer("order_201");

        // All three results in the same cycle.
        do_reset();
        words = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
        sched = '{0, 0, 0};
        vals  = '{16'h1234, 16'hBEEF, 16'h8001};
        run_layer("same_cycle");

        // Neuron 1 never answers: timeout, hole reads as zero.
        do_reset();
        sched = '{3, -1, 5};
        vals  = '{16'h00A5, 16'h7777, 16'h005A};
        run_layer("timeout");

        // Last result lands on the final WAIT cycle: capture beats timeout.
        do_reset();
        sched = '{0, TO - 1, 2};
        vals  = '{16'h0001, 16'h0002, 16'h0003};
        run_layer("edge_capture");

        // Back-pressured drain.
        do_reset();
        sched = '{2, 1, 0};
        vals  = '{16'hC001, 16'hC002, 16'hC003};
        ready_mode = 1;
        run_layer("stall");
        ready_mode = 0;

        // Result pulse while idle is an error.
        do_reset();
        n_outValid = 3'b001;
        @(negedge clk);
        n_outValid = '0;
        @(negedge clk);
        chk("idle_pulse_err", err, 1);
        chk("idle_pulse_busy", busy, 0);

        // Reset after two accepts, then a fresh vector.
        do_reset();
        s_valid = 1'b1; s_data = 16'h00AA;
        chk("abort_ready1", s_ready, 1);
        @(negedge clk);
        s_data = 16'h00BB;
        chk("abort_ready2", s_ready, 1);
        @(negedge clk);
        chk("abort_in_valid", n_inputValid, 1);
        chk("abort_in_data", n_input, 16'h00BB);
        chk("abort_busy_pre", busy, 1);
        reset = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_in_valid_drop", n_inputValid, 0);
        reset = 1'b0; err_exp = 1'b0;
        @(negedge clk);
        words = '{16'd5, 16'd6, 16'd7, 16'd8};
        sched = '{1, 0, 2};
        vals  = '{16'h0F0F, 16'hF0F0, 16'h5555};
        run_layer("after_abort");

        // Randomized vectors without intervening reset (err is sticky).
        do_reset();
        gap_pct    = 30;
        ready_mode = 2;
        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < NW; k++) words[k] = DW'($urandom);
            for (int i = 0; i < NN; i++) begin
                sched[i] = ($urandom_range(5) == 0) ? -1 : int'($urandom_range(TO + 2));
                vals[i]  = DW'($urandom);
            end
            dup_req = ($urandom_range(2) == 0) ? int'($urandom_range(NN - 1)) : -1;
            run_layer($sformatf("rand%0d", v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
